spi_regfile_peripheral: RTL
===========================

# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral that gives an external controller write and read access to a bank of `NUM_REGS` configuration registers of `DATA_W` bits each. All SPI pins are oversampled in the `clk` domain. Writes commit atomically only on a correctly framed transaction, and reads return register contents on `CIPO`. It is the register front-end for the PWM/output-enable logic and replaces the fixed 5×8-bit write-only peripheral.

## Interface
- `SYNC_FLOPS`, 2: synchroniser depth for `SCLK`, `COPI` and `nCS`; minimum 2.
- `ADDR_W`, 7: address field width.
- `DATA_W`, 8: data field width and register width.
- `NUM_REGS`, 5: number of implemented registers, at addresses 0..`NUM_REGS`-1; at most 2^`ADDR_W`.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `SCLK`  input  1  SPI clock, asynchronous to `clk`.
- `COPI`  input  1  SPI data from the controller.
- `nCS`  input  1  SPI chip select, active-low.
- `CIPO`  output  1  SPI data to the controller.
- `cipo_oe`  output  1  high while a read data phase is active; used for the pad tri-state.
- `regs_out`  output  `NUM_REGS`*`DATA_W`  flat register bank; register i occupies bits [i*`DATA_W` +: `DATA_W`].
- `wr_pulse`  output  1  one-`clk` pulse when a write commits.
- `wr_addr`  output  `ADDR_W`  address of the last committed write; held between writes.
- `frame_err`  output  1  one-`clk` pulse when a frame is discarded or addresses an unimplemented register.

## Operation
- Frame format: `FRAME_W` = 1+`ADDR_W`+`DATA_W` bits, MSB first.
  - Bit 0 is R/W: 1 = write, 0 = read.
  - Then the address, then the data.
- Mode 0: `COPI` is sampled on synchronised `SCLK` rise; `CIPO` is updated on synchronised `SCLK` fall.
- Edge detection compares the last synchroniser stage with one extra history flop.
- The sampled `COPI` value is taken from the same pipeline stage as `SCLK`.
- States:
  - IDLE: waits for `nCS` fall.
  - CMD: shifts in R/W and address; after 1+`ADDR_W` bits goes to WDATA or RDATA.
  - WDATA: shifts `DATA_W` bits into the shift register.
  - RDATA: drives register contents out, MSB first; `COPI` bits are counted but ignored.
  - DONE: entered once `FRAME_W` bits are received.
  - OVERRUN: entered on any further `SCLK` rise while in DONE; stays until `nCS` rises.
- `nCS` fall from any state: clear the bit counter and shift register, go to CMD.
- `nCS` rise:
  - From DONE with a write to an address < `NUM_REGS`: commit the data, pulse `wr_pulse`, load `wr_addr`.
  - From DONE with a write to an address ≥ `NUM_REGS`: no commit, pulse `frame_err`.
  - From CMD, WDATA or RDATA (short frame): no commit, pulse `frame_err`.
  - From OVERRUN: no commit, pulse `frame_err`.
  - From DONE with a read: no error.
  - Every case returns to IDLE.
- Read path:
  - On entry to RDATA, latch the addressed register. Unimplemented addresses latch 0 and set a sticky error that pulses `frame_err` at `nCS` rise.
  - Drive bit `DATA_W`-1 on `CIPO` immediately on entry.
  - Each subsequent `SCLK` fall shifts to the next bit.
  - After the last bit, hold `CIPO` at 0.
  - The latch makes a read atomic: a concurrent write cannot occur, since the bus is single-master.
- `cipo_oe` is high from RDATA entry until `nCS` rise; `CIPO` is 0 whenever `cipo_oe` is low.
- A `nCS` fall and rise detected in the same `clk` cycle (glitch) are treated as a rise: abort, pulse `frame_err`, go to IDLE.
- Bit counter width is clog2(`FRAME_W`+1). It saturates at `FRAME_W`; OVERRUN is a state, not a wrapped count.

## Timing
- Reset values:
  - `regs_out` all 0; `CIPO`, `cipo_oe`, `wr_pulse`, `frame_err` all 0; `wr_addr` 0.
  - State IDLE; synchroniser flops 1 for `nCS`, 0 for `SCLK` and `COPI`.
- Reset asserted mid-frame: the frame is lost and no commit occurs. After release, the first `nCS` fall is required before any frame is accepted.
- Pin-to-detection latency is `SYNC_FLOPS`+1 `clk` edges.
- A commit is visible on `regs_out`, with `wr_pulse` high, on the `clk` edge after `nCS` rise detection. Total latency from the pin is `SYNC_FLOPS`+2 cycles.
- `CIPO` changes `SYNC_FLOPS`+2 `clk` cycles after the `SCLK` falling pin edge.
- Required SCLK timing: low and high phases each ≥ `SYNC_FLOPS`+3 `clk` periods; `nCS` setup/hold to `SCLK` ≥ `SYNC_FLOPS`+2 periods. Violations give undefined data, but the FSM never deadlocks.
- `wr_pulse` and `frame_err` are exactly one cycle wide and never high together.

## Test plan
- Write frame R/W=1, addr 0x02, data 0xA5 (`FRAME_W`=16) -> only register 2 reads 0xA5 after `nCS` rise; `wr_pulse` pulses once; `wr_addr`=2.
- Read after that write, addr 0x02 -> `CIPO` shifts 1,0,1,0,0,1,0,1 on data-phase falls; `cipo_oe` high until `nCS` rise; `regs_out` unchanged.
- Short frame of 12 bits, write addr 0x00 -> `regs_out` unchanged; one `frame_err` pulse.
- Overrun of 17 bits, write addr 0x01 -> no commit; `frame_err` pulse.
- Write to addr 0x7F, and read of addr 0x7F -> no commit; the read returns 0x00; each pulses `frame_err`.
- `rst_n` low after 10 bits of a write, then a full write of 0x3C to addr 4 -> first frame has no effect, register 4 = 0x3C. Repeat with `DATA_W`=16, `ADDR_W`=4, `NUM_REGS`=12, `SYNC_FLOPS`=3 and expect the same outcomes.

Source files
------------

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral: NUM_REGS x DATA_W registers, written and read over an
// oversampled SPI link; writes commit only when the frame is exactly FRAME_W bits long.
module spi_regfile_peripheral #(
  parameter int SYNC_FLOPS = 2,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE, OVERRUN} state_t;

  state_t state, state_nxt;

  logic [SYNC_FLOPS-1:0] sclk_sync, copi_sync, cs_sync;
  logic                  sclk_hist, cs_hist;
  logic                  sclk_rise, sclk_fall, cs_fall, cs_rise, copi_bit;

  logic [FRAME_W-1:0]    shreg, shreg_shift;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic [DATA_W-1:0]     regs [NUM_REGS];
  logic [DATA_W-1:0]     rd_val, rd_shreg;
  logic [ADDR_W-1:0]     cmd_addr, frame_addr;
  logic [DATA_W-1:0]     frame_data;
  logic                  cmd_rw, frame_rw, rd_err;
  logic                  commit, err_nxt, clear, shift, rd_load;

  function automatic logic implemented(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  // Edge pulses are registered, so the FSM acts one cycle after the edge is seen in the
  // last synchroniser stage; COPI is captured from the same stage as SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      cs_sync   <= '1;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      copi_bit  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous value of the
      // stage before it, which is what makes this a shift chain rather than a wire.
      sclk_sync <= {sclk_sync[SYNC_FLOPS-2:0], SCLK};
      copi_sync <= {copi_sync[SYNC_FLOPS-2:0], COPI};
      cs_sync   <= {cs_sync[SYNC_FLOPS-2:0], nCS};
      sclk_hist <= sclk_sync[SYNC_FLOPS-1];
      cs_hist   <= cs_sync[SYNC_FLOPS-1];
      sclk_rise <= sclk_sync[SYNC_FLOPS-1] & ~sclk_hist;
      sclk_fall <= ~sclk_sync[SYNC_FLOPS-1] & sclk_hist;
      cs_fall   <= ~cs_sync[SYNC_FLOPS-1] & cs_hist;
      cs_rise   <= cs_sync[SYNC_FLOPS-1] & ~cs_hist;
      copi_bit  <= copi_sync[SYNC_FLOPS-1];
    end
  end

  assign shreg_shift = {shreg[FRAME_W-2:0], copi_bit};
  assign cnt_inc     = cnt + CNT_W'(1);
  assign cmd_rw      = shreg_shift[ADDR_W];
  assign cmd_addr    = shreg_shift[ADDR_W-1:0];
  assign frame_rw    = shreg[FRAME_W-1];
  assign frame_addr  = shreg[DATA_W +: ADDR_W];
  assign frame_data  = shreg[DATA_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_addr == ADDR_W'(i)) rd_val = regs[i];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    clear     = 1'b0;
    shift     = 1'b0;
    rd_load   = 1'b0;
    if (cs_rise) begin
      state_nxt = IDLE;
      case (state)
        DONE: begin
          if (frame_rw) begin
            if (implemented(frame_addr)) commit = 1'b1;
            else                         err_nxt = 1'b1;
          end else begin
            err_nxt = rd_err;
          end
        end
        CMD, WDATA, RDATA, OVERRUN: err_nxt = 1'b1;
        default: ;
      endcase
    end else if (cs_fall) begin
      state_nxt = CMD;
      clear     = 1'b1;
    end else if (sclk_rise) begin
      case (state)
        CMD: begin
          shift = 1'b1;
          if (cnt_inc == CNT_W'(1 + ADDR_W)) begin
            if (cmd_rw) begin
              state_nxt = WDATA;
            end else begin
              state_nxt = RDATA;
              rd_load   = 1'b1;
            end
          end
        end
        WDATA, RDATA: begin
          shift = 1'b1;
          if (cnt_inc == CNT_W'(FRAME_W)) state_nxt = DONE;
        end
        DONE:    state_nxt = OVERRUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      rd_shreg  <= '0;
      rd_err    <= 1'b0;
      cipo_oe   <= 1'b0;
      CIPO      <= 1'b0;
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      // NOTE: the register bank is reset on purpose; downstream PWM logic must see zeros.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      wr_pulse  <= commit;
      frame_err <= err_nxt;

      if (clear) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (shift) begin
        cnt   <= cnt_inc;
        shreg <= shreg_shift;
      end

      if (commit) begin
        wr_addr <= frame_addr;
        for (int i = 0; i < NUM_REGS; i++)
          if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
      end

      // The first fall after RDATA entry keeps the MSB so the controller samples it on the
      // first data rise; later falls advance one bit, and after the last bit CIPO drops to 0.
      if (cs_rise || cs_fall) begin
        cipo_oe <= 1'b0;
        CIPO    <= 1'b0;
        rd_err  <= 1'b0;
      end else if (rd_load) begin
        rd_shreg <= rd_val;
        rd_err   <= ~implemented(cmd_addr);
        cipo_oe  <= 1'b1;
        CIPO     <= rd_val[DATA_W-1];
      end else if (sclk_fall && cipo_oe) begin
        if (state == RDATA) begin
          if (cnt != CNT_W'(1 + ADDR_W)) begin
            rd_shreg <= rd_shreg << 1;
            CIPO     <= rd_shreg[DATA_W-2];
          end
        end else begin
          CIPO <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
